// File: rtl/dmem_arbiter.sv
// Round-robin arbiter placing two valid/ready masters in front of a single-port data memory,
// with a built-in sweep that writes zero to every word on command.
module dmem_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid0,
  input  logic          valid1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ready0,
  output logic          ready1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] counter_reg;
  logic          last_grant_reg;
  logic          grant_any;
  logic          grant_sel;
  logic          sweep_end;

  // A grant is only possible in IDLE when no sweep is being requested.
  assign grant_any = (state_reg == IDLE) && !clear_start && (valid0 || valid1);
  assign grant_sel = (valid0 && valid1) ? ~last_grant_reg : valid1;
  assign sweep_end = (state_reg == CLEAR) && (counter_reg == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (sweep_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready0     = 1'b0;
    ready1     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    clear_busy = (state_reg == CLEAR);
    if (state_reg == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = AW'(counter_reg);
    end else if (grant_any) begin
      ready0   = !grant_sel;
      ready1   = grant_sel;
      mem_we   = grant_sel ? we1 : we0;
      mem_addr = grant_sel ? addr1 : addr0;
      mem_wd   = grant_sel ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg    <= '0;
      last_grant_reg <= 1'b1;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      clear_done     <= 1'b0;
    end else begin
      clear_done <= sweep_end;
      if (state_reg == IDLE || sweep_end) begin
        counter_reg <= '0;
      end else begin
        counter_reg <= counter_reg + 1'b1;
      end
      if (grant_any) begin
        last_grant_reg <= grant_sel;
      end
      // Read data is captured at the accepting edge; writes leave rdata untouched.
      rvalid0 <= grant_any && !grant_sel && !we0;
      rvalid1 <= grant_any && grant_sel && !we1;
      if (grant_any && !grant_sel && !we0) begin
        rdata0 <= mem_rd;
      end
      if (grant_any && grant_sel && !we1) begin
        rdata1 <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read data into per-port queues,
// a negedge monitor pops and compares on every rvalid pulse.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        valid0, valid1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ready0, ready1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        clear_start, clear_busy, clear_done;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:255];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;
  int checks;
  int failures;

  dmem_arbiter #(.DW(32), .AW(32), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .valid0(valid0), .valid1(valid1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready0(ready0), .ready1(ready1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on rising edge.
  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid0_unexpected actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", rdata0, e0);
      end
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid1_unexpected actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", rdata1, e1);
      end
    end
  end

  initial begin
    int busy_cnt;
    int done_seen;
    checks = 0; failures = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[0]   <= 32'h0000_0011;
    mem[1]   <= 32'hA1A1_A1A1;
    mem[2]   <= 32'hB2B2_B2B2;
    mem[5]   <= 32'hDEAD_BEEF;
    mem[255] <= 32'h0000_0022;
    reset = 1'b1; clear_start = 1'b0;
    valid0 = 1'b1; valid1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd1; addr1 = 32'd2; wdata0 = '0; wdata1 = '0;

    // Reset with both ports requesting: no rvalid may follow.
    next_cycle(); sample();
    next_cycle(); sample();
    chk("reset_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("reset_rvalid1", {31'b0, rvalid1}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_clear_busy", {31'b0, clear_busy}, 32'd0);

    // Conflict fairness: grants alternate starting with port 0.
    next_cycle(); reset = 1'b0; sample();
    chk("fair_c1_ready0", {31'b0, ready0}, 32'd1);
    chk("fair_c1_ready1", {31'b0, ready1}, 32'd0);
    chk("fair_c1_addr", mem_addr, 32'd1);
    q0.push_back(32'hA1A1_A1A1);
    next_cycle(); sample();
    chk("fair_c2_ready1", {31'b0, ready1}, 32'd1);
    chk("fair_c2_addr", mem_addr, 32'd2);
    chk("fair_c2_rvalid0", {31'b0, rvalid0}, 32'd1);
    q1.push_back(32'hB2B2_B2B2);
    next_cycle(); sample();
    chk("fair_c3_ready0", {31'b0, ready0}, 32'd1);
    chk("fair_c3_rvalid1", {31'b0, rvalid1}, 32'd1);
    chk("fair_c3_rvalid0", {31'b0, rvalid0}, 32'd0);
    q0.push_back(32'hA1A1_A1A1);
    next_cycle(); sample();
    chk("fair_c4_ready1", {31'b0, ready1}, 32'd1);
    chk("fair_c4_ready0", {31'b0, ready0}, 32'd0);
    q1.push_back(32'hB2B2_B2B2);

    // Idle cycle: nothing granted, memory quiet.
    next_cycle(); valid0 = 1'b0; valid1 = 1'b0; sample();
    chk("idle_mem_we", {31'b0, mem_we}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_ready0", {31'b0, ready0}, 32'd0);

    // Single read of address 5.
    next_cycle(); valid0 = 1'b1; addr0 = 32'd5; sample();
    chk("single_ready0", {31'b0, ready0}, 32'd1);
    chk("single_mem_addr", mem_addr, 32'd5);
    q0.push_back(32'hDEAD_BEEF);
    next_cycle(); valid0 = 1'b0; sample();
    chk("single_rvalid0_n1", {31'b0, rvalid0}, 32'd1);
    next_cycle(); sample();
    chk("single_rvalid0_n2", {31'b0, rvalid0}, 32'd0);

    // Port 1 writes address 7, port 0 reads it back next cycle.
    next_cycle(); valid1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h1234_5678; sample();
    chk("wr_ready1", {31'b0, ready1}, 32'd1);
    chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr_mem_wd", mem_wd, 32'h1234_5678);
    next_cycle(); valid1 = 1'b0; we1 = 1'b0; valid0 = 1'b1; addr0 = 32'd7; sample();
    chk("rd7_ready0", {31'b0, ready0}, 32'd1);
    q0.push_back(32'h1234_5678);
    next_cycle(); valid0 = 1'b0; sample();
    chk("rd7_rvalid0", {31'b0, rvalid0}, 32'd1);
    chk("rd7_rdata1_hold", rdata1, 32'hB2B2_B2B2);

    // Full clear sweep with port 0 requesting throughout.
    next_cycle(); valid0 = 1'b1; addr0 = 32'd0; clear_start = 1'b1; sample();
    chk("clr_start_ready0", {31'b0, ready0}, 32'd0);
    chk("clr_start_mem_we", {31'b0, mem_we}, 32'd0);
    busy_cnt = 0; done_seen = 0;
    for (int i = 0; i < 400 && done_seen == 0; i++) begin
      next_cycle(); clear_start = 1'b0; sample();
      if (clear_busy) begin
        busy_cnt++;
        chk("clr_ready0", {31'b0, ready0}, 32'd0);
        chk("clr_mem_we", {31'b0, mem_we}, 32'd1);
        chk("clr_mem_addr", mem_addr, busy_cnt - 1);
        chk("clr_mem_wd", mem_wd, 32'd0);
      end
      if (clear_done) begin
        done_seen = 1;
        chk("done_busy_cycles", busy_cnt, 32'd256);
        chk("done_clear_busy", {31'b0, clear_busy}, 32'd0);
        chk("done_ready0", {31'b0, ready0}, 32'd1);
        chk("done_mem_addr", mem_addr, 32'd0);
        q0.push_back(32'd0);
      end
    end
    if (done_seen == 0) chk("clear_done_timeout", 32'd0, 32'd1);
    next_cycle(); addr0 = 32'd255; sample();
    chk("done_single_pulse", {31'b0, clear_done}, 32'd0);
    chk("rd255_ready0", {31'b0, ready0}, 32'd1);
    q0.push_back(32'd0);
    next_cycle(); valid0 = 1'b0; sample();

    // Reset in the cycle the sweep writes address 100.
    next_cycle(); mem[200] <= 32'hCAFE_F00D; clear_start = 1'b1; sample();
    for (int i = 0; i < 100; i++) begin
      next_cycle(); clear_start = 1'b0; sample();
      chk("mid_mem_addr", mem_addr, i);
    end
    next_cycle(); reset = 1'b1; sample();
    chk("mid_addr100", mem_addr, 32'd100);
    chk("mid_busy_before", {31'b0, clear_busy}, 32'd1);
    next_cycle(); reset = 1'b0; sample();
    chk("mid_busy_after", {31'b0, clear_busy}, 32'd0);
    chk("mid_no_done", {31'b0, clear_done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); sample();
      chk("mid_no_done_later", {31'b0, clear_done}, 32'd0);
    end
    chk("mid_mem200_kept", mem[200], 32'hCAFE_F00D);
    next_cycle(); valid0 = 1'b1; addr0 = 32'd200; sample();
    chk("rd200_ready0", {31'b0, ready0}, 32'd1);
    q0.push_back(32'hCAFE_F00D);
    next_cycle(); valid0 = 1'b0; sample();
    chk("rd200_rvalid0", {31'b0, rvalid0}, 32'd1);

    next_cycle(); sample();
    next_cycle(); sample();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
